// File: rtl/jtframe_credits_vram_arb_if.sv
// Bundle of the two requester ports, the clear control and the credits VRAM port.
// The arbiter uses the slave view; the master view drives requests and returns RAM data.
interface jtframe_credits_vram_arb_if #(
  parameter int AW = 10
);
  logic          r0_req,  r1_req;
  logic          r0_we,   r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [7:0]    r0_din,  r1_din;
  logic          r0_ack,  r1_ack;
  logic [7:0]    r0_dout, r1_dout;
  logic          clr_start;
  logic          clr_busy;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_din;
  logic          vram_we;
  logic [7:0]    vram_dout;

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_din, r1_din,
           clr_start, vram_dout,
    input  r0_ack, r1_ack, r0_dout, r1_dout, clr_busy, vram_addr, vram_din, vram_we
  );

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_din, r1_din,
           clr_start, vram_dout,
    output r0_ack, r1_ack, r0_dout, r1_dout, clr_busy, vram_addr, vram_din, vram_we
  );
endinterface

// File: rtl/jtframe_credits_vram_arb.sv
// Two-requester round-robin arbiter for the credits VRAM with a full-screen clear engine.
// Every access takes four cycles: grant, RAM address, RAM data capture, ack.
module jtframe_credits_vram_arb #(
  parameter logic [7:0] CLR_VAL = 8'h20,
  parameter int         AW      = 10
) (
  input logic                 clk,
  input logic                 rst,
  jtframe_credits_vram_arb_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC, RD, ACK, CLEAR} state_t;

  state_t        state, state_nx;
  logic          gnt, gnt_nx;      // requester currently being served
  logic          prio, prio_nx;    // 1: r1 wins a tie
  logic          pend, pend_nx;
  logic          busy, busy_nx;
  logic          we, we_nx;
  logic          ack0, ack0_nx, ack1, ack1_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [7:0]    din, din_nx;
  logic [7:0]    dout0, dout0_nx, dout1, dout1_nx;
  logic          pick;

  assign pick = bus.r1_req & (~bus.r0_req | prio);

  assign bus.vram_addr = addr;
  assign bus.vram_din  = din;
  assign bus.vram_we   = we;
  assign bus.r0_ack    = ack0;
  assign bus.r1_ack    = ack1;
  assign bus.r0_dout   = dout0;
  assign bus.r1_dout   = dout1;
  assign bus.clr_busy  = busy;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    prio_nx  = prio;
    pend_nx  = pend | (bus.clr_start & (state != IDLE));
    busy_nx  = busy;
    we_nx    = 1'b0;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    addr_nx  = addr;
    din_nx   = din;
    dout0_nx = dout0;
    dout1_nx = dout1;
    case (state)
      IDLE: begin
        if (bus.clr_start || pend) begin
          state_nx = CLEAR;
          pend_nx  = 1'b0;
          busy_nx  = 1'b1;
          we_nx    = 1'b1;
          addr_nx  = '0;
          din_nx   = CLR_VAL;
        end else if (bus.r0_req || bus.r1_req) begin
          state_nx = ACC;
          gnt_nx   = pick;
          prio_nx  = ~pick;
          we_nx    = pick ? bus.r1_we   : bus.r0_we;
          addr_nx  = pick ? bus.r1_addr : bus.r0_addr;
          din_nx   = pick ? bus.r1_din  : bus.r0_din;
        end
      end
      ACC: state_nx = RD;
      RD: begin
        state_nx = ACK;
        if (gnt) begin
          dout1_nx = bus.vram_dout;
          ack1_nx  = 1'b1;
        end else begin
          dout0_nx = bus.vram_dout;
          ack0_nx  = 1'b1;
        end
      end
      ACK: state_nx = IDLE;
      CLEAR: begin
        if (&addr) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          addr_nx  = '0;
        end else begin
          we_nx   = 1'b1;
          addr_nx = addr + AW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
      pend  <= 1'b0;
      busy  <= 1'b0;
      we    <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      addr  <= '0;
      din   <= '0;
      dout0 <= '0;
      dout1 <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      prio  <= prio_nx;
      pend  <= pend_nx;
      busy  <= busy_nx;
      we    <= we_nx;
      ack0  <= ack0_nx;
      ack1  <= ack1_nx;
      addr  <= addr_nx;
      din   <= din_nx;
      dout0 <= dout0_nx;
      dout1 <= dout1_nx;
    end
  end

endmodule

// File: tb/tb_jtframe_credits_vram_arb.sv
// Self-checking bench: a behavioural VRAM plus a golden content array and a
// served-last tracker predict every grant, ack timing, read value and clear.
module tb_jtframe_credits_vram_arb;
  localparam int         AW    = 10;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] CLR   = 8'h20;

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  jtframe_credits_vram_arb_if #(.AW(AW)) bus ();

  jtframe_credits_vram_arb #(.CLR_VAL(CLR), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous RAM seen by the arbiter.
  logic [7:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.vram_we) ram[bus.vram_addr] <= bus.vram_din;
    bus.vram_dout <= ram[bus.vram_addr];
  end

  logic [7:0] golden [0:DEPTH-1];
  bit         last_srv;   // requester served last; 1 after reset so r0 wins the first tie

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vram"}, {bus.vram_we, bus.vram_addr, bus.vram_din}, 0);
    check({tag, "_acks"}, {bus.r0_ack, bus.r1_ack, bus.clr_busy}, 0);
    check({tag, "_douts"}, {bus.r0_dout, bus.r1_dout}, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic golden_fill_clear();
    for (int i = 0; i < DEPTH; i++) golden[i] = CLR;
  endtask

  // One arbitration round starting in an IDLE cycle; ends in the following IDLE cycle.
  task automatic round(input bit q0, input bit q1, input bit w0, input bit w1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    bit            win;
    bit            ww;
    logic [AW-1:0] wa;
    logic [7:0]    wd;
    win = (q0 && q1) ? !last_srv : q1;
    ww  = win ? w1 : w0;
    wa  = win ? a1 : a0;
    wd  = win ? d1 : d0;
    bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_din = d0;
    bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_din = d1;
    tick();
    check("grant_we", bus.vram_we, ww);
    check("grant_addr", bus.vram_addr, wa);
    if (ww) check("grant_din", bus.vram_din, wd);
    check("ack_early1", {bus.r0_ack, bus.r1_ack}, 0);
    tick();
    check("we_single", bus.vram_we, 0);
    check("ack_early2", {bus.r0_ack, bus.r1_ack}, 0);
    tick();
    check("ack_winner", {bus.r0_ack, bus.r1_ack}, win ? 2'b01 : 2'b10);
    if (!ww) check("read_data", win ? bus.r1_dout : bus.r0_dout, golden[wa]);
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    if (ww) golden[wa] = wd;
    last_srv = win;
    tick();
    check("ack_width", {bus.r0_ack, bus.r1_ack}, 0);
  endtask

  task automatic wait_ack(output bit who, output bit ok);
    ok  = 1'b0;
    who = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (bus.r0_ack || bus.r1_ack) begin
        check("ack_exclusive", bus.r0_ack & bus.r1_ack, 0);
        who = bus.r1_ack;
        ok  = 1'b1;
      end
    end
    check("ack_timeout", ok, 1);
  endtask

  initial begin
    int            bad;
    int            n;
    bit            who;
    bit            ok;
    logic [AW-1:0] a0, a1;
    logic [1:0]    q;

    for (int i = 0; i < DEPTH; i++) golden[i] = 8'h00;
    rst = 1'b1;
    bus.r0_req = 0; bus.r1_req = 0; bus.r0_we = 0; bus.r1_we = 0;
    bus.r0_addr = '0; bus.r1_addr = '0; bus.r0_din = '0; bus.r1_din = '0;
    bus.clr_start = 1'b0;
    last_srv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Write then read back from the other requester.
    round(1, 0, 1, 0, AW'(5), '0, 8'h41, 8'h00);
    round(0, 1, 0, 0, '0, AW'(5), 8'h00, 8'h00);
    check("s2_r1_dout", bus.r1_dout, 8'h41);

    // Full clear with an r0 read raised in the middle of it.
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    golden_fill_clear();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(bus.clr_busy && bus.vram_we && bus.vram_addr == AW'(i) && bus.vram_din == CLR)) bad++;
      if (bus.r0_ack || bus.r1_ack) bad++;
      if (i == 500) begin
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = AW'('h123);
      end
      tick();
    end
    check("s4_clear_seq_errs", bad, 0);
    check("s4_clear_end", {bus.clr_busy, bus.vram_we, bus.vram_addr}, 0);
    tick();
    check("s4_grant_addr", bus.vram_addr, AW'('h123));
    check("s4_ack_early", bus.r0_ack, 0);
    tick();
    check("s4_ack_early2", bus.r0_ack, 0);
    tick();
    check("s4_ack", {bus.r0_ack, bus.r1_ack}, 2'b10);
    check("s4_dout", bus.r0_dout, CLR);
    bus.r0_req = 1'b0;
    last_srv = 1'b0;
    tick();

    // Both requesters hold req: grants must alternate.
    a0 = AW'($urandom); a1 = AW'($urandom);
    golden[a0] = 8'h5a; golden[a1] = 8'ha5;
    round(1, 0, 1, 0, a0, '0, 8'h5a, 8'h00);
    if (a1 != a0) round(0, 1, 0, 1, '0, a1, 8'h00, 8'ha5);
    else golden[a1] = 8'h5a;
    bus.r0_req = 1; bus.r0_we = 0; bus.r0_addr = a0;
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = a1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(who, ok);
      if (!ok) break;
      check("s3_alternate", who, !last_srv);
      check("s3_dout", who ? bus.r1_dout : bus.r0_dout, who ? golden[a1] : golden[a0]);
      last_srv = who;
      if (k == 5) begin
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
      end
    end
    tick();

    // Clear pulsed twice during an r1 access: one merged clear after the ack.
    bus.r1_req = 1; bus.r1_we = 0; bus.r1_addr = a1;
    tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("s5_no_busy_rd", bus.clr_busy, 0);
    tick();
    bus.clr_start = 1'b1;
    check("s5_ack", {bus.r0_ack, bus.r1_ack}, 2'b01);
    check("s5_dout", bus.r1_dout, golden[a1]);
    bus.r1_req = 1'b0;
    last_srv = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("s5_idle_gap", bus.clr_busy, 0);
    tick();
    check("s5_clear_start", {bus.clr_busy, bus.vram_we, bus.vram_addr}, {2'b11, AW'(0)});
    golden_fill_clear();
    n = 1;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (!bus.clr_busy) break;
      n++;
    end
    check("s5_busy_len", n, DEPTH);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.clr_busy) bad++;
    end
    check("s5_merged", bad, 0);

    // Randomized single rounds.
    for (int r = 0; r < 40; r++) begin
      q = 2'($urandom_range(1, 3));
      round(q[0], q[1], 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
            8'($urandom), 8'($urandom));
    end

    // Reset in the middle of a clear.
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (512) tick();
    check("s6_addr_before_rst", bus.vram_addr, AW'('h200));
    rst = 1'b1;
    #1;
    check_all_zero("s6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_srv = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.vram_we || bus.clr_busy) bad++;
    end
    check("s6_quiet", bad, 0);
    round(1, 1, 0, 0, AW'('h1ff), AW'('h3ff), 8'h00, 8'h00);
    for (int r = 0; r < 10; r++) begin
      q = 2'($urandom_range(1, 3));
      round(q[0], q[1], 1'($urandom), 1'($urandom), AW'($urandom_range(0, 'h1ff)),
            AW'($urandom_range(0, 'h1ff)), 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtframe_credits_vram_arb.md
JTFRAME_CREDITS_VRAM_ARB -- requirements
Module: jtframe_credits_vram_arb

Interface
REQ-001 SHALL have parameter CLR_VAL, default 8'h20: fill byte written by the clear engine.
REQ-002 SHALL have parameter AW, default 10: VRAM address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports r0_req/r1_req, input, 1 bit each: access request, held high until the matching ack.
REQ-006 SHALL have ports r0_we/r1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports r0_addr/r1_addr, input, AW bits each: VRAM cell address.
REQ-008 SHALL have ports r0_din/r1_din, input, 8 bits each: write data.
REQ-009 SHALL have ports r0_ack/r1_ack, output, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have ports r0_dout/r1_dout, output, 8 bits each: read data, valid while the matching ack is high and held afterwards.
REQ-011 SHALL have port clr_start, input, 1 bit: requests a full VRAM clear.
REQ-012 SHALL have port clr_busy, output, 1 bit: high while a clear is running.
REQ-013 SHALL have ports vram_addr (AW bits), vram_din (8 bits) and vram_we (1 bit), all outputs: drive the credits VRAM port.
REQ-014 SHALL have port vram_dout, input, 8 bits: synchronous RAM output, valid one cycle after the address is presented.
REQ-015 SHALL drive every output from a register.

Function
REQ-016 SHALL implement an FSM with states IDLE, ACC, RD, ACK and CLEAR.
REQ-017 IDLE SHALL enter CLEAR when clr_start=1, with priority over both requesters.
REQ-018 IDLE without clr_start and with any request SHALL grant one requester, register its addr, din and we onto the vram outputs, and enter ACC.
REQ-019 Arbitration SHALL be round-robin: the requester not served last wins a tie; after reset r0 wins.
REQ-020 vram_we SHALL be high only during the single ACC cycle of a write grant; it SHALL stay low for reads.
REQ-021 ACC SHALL go to RD unconditionally.
REQ-022 In RD, the FSM SHALL capture vram_dout into the granted requester's dout register, raise that requester's ack for the next cycle, and enter ACK.
REQ-023 Captured dout for a write SHALL be the RAM's read-during-write value; it is don't-care.
REQ-024 ACK SHALL last one cycle with ack=1, make no new grant, and return to IDLE.
REQ-025 Fixed latency SHALL be: request sampled in IDLE at cycle N gives ack high in cycle N+3; maximum throughput is one access per 4 cycles.
REQ-026 A requester that drops req before ack SHALL still complete the granted access.
REQ-027 A requester keeping req high after ack SHALL be treated as a new request.
REQ-028 CLEAR SHALL write CLR_VAL to addresses 0 .. 2^AW-1 in ascending order, one per cycle, with vram_we=1 throughout.
REQ-029 After writing the last address, CLEAR SHALL drop vram_we, wrap vram_addr to 0, and return to IDLE.
REQ-030 clr_busy SHALL be high in exactly the 2^AW CLEAR cycles.
REQ-031 clr_start while clr_busy=1, or during ACC/RD/ACK, SHALL be latched as pending and serviced at the next IDLE.
REQ-032 Only one clear SHALL be pending at a time; further pulses while a clear is pending merge into it.
REQ-033 Requests arriving during CLEAR SHALL wait with no ack and SHALL be arbitrated in the first IDLE after the clear.
REQ-034 The ack outputs SHALL never be high simultaneously.

Reset
REQ-035 Asserting rst in any state SHALL immediately force: state=IDLE, vram_we=0, vram_addr=0, vram_din=0, r0_ack=r1_ack=0, r0_dout=r1_dout=0, clr_busy=0, clear-pending=0, round-robin pointer=r0.
REQ-036 An access or clear interrupted by reset SHALL be abandoned and not resumed after reset.

Verification
REQ-037 Scenario 1: r0 write addr 0x005 data 0x41 -> vram_we=1 with addr 0x005 / din 0x41 for one cycle; r0_ack pulses 3 cycles after the request is sampled.
REQ-038 Scenario 2: r1 read addr 0x005 after scenario 1 -> r1_dout=0x41 with r1_ack; r0_ack stays 0.
REQ-039 Scenario 3: r0 and r1 both request continuously -> grants alternate r0, r1, r0, r1; never two consecutive grants to the same requester.
REQ-040 Scenario 4: clr_start with AW=10 -> clr_busy high exactly 1024 cycles, writes 0x20 to 0x000..0x3FF; a r0 request raised mid-clear is acked 3 cycles after the clear ends.
REQ-041 Scenario 5: clr_start pulsed during an r1 access -> r1 completes, then the clear starts from the next IDLE.
REQ-042 Scenario 6: rst asserted at clear address 0x200 -> all outputs are 0 in the same cycle; after release no writes occur until a new request or clr_start.
